// File: rtl/pulse_stretcher.sv
// Stretches each trigger on din into an L-cycle dout pulse followed by GAP low cycles.
// Define PULSE_QUEUE_EN to buffer triggers that arrive while busy instead of dropping them.
module pulse_stretcher #(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned GAP    = 1,
    parameter int unsigned QDEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             din,
    input  logic [LEN_W-1:0] len,
    output logic             dout,
    output logic             busy,
    output logic             drop
);

    localparam int unsigned CW = (LEN_W > 4) ? LEN_W : 4;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

    if (GAP < 1 || GAP > 15) begin : g_gap_chk
        $error("pulse_stretcher: GAP must be in 1..15");
    end
    if (QDEPTH == 0 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_qdepth_chk
        $error("pulse_stretcher: QDEPTH must be a power of two");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          drop_c;
    logic          trig_busy_c;

    // Counter load for a HIGH phase: L-1, with len=0 treated as L=1.
    function automatic logic [CW-1:0] hi_load(input logic [LEN_W-1:0] l);
        return (l == '0) ? '0 : CW'(l) - CW'(1);
    endfunction

`ifdef PULSE_QUEUE_EN
    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [LEN_W-1:0] fifo [QDEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic             push_c, pop_c, full_c;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(QDEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_c    = (count == (AW+1)'(QDEPTH));
    assign count_nxt = count + (AW+1)'(push_c) - (AW+1)'(pop_c);
`endif

    // A trigger that lands while a pulse or its gap is in progress (final gap cycle handled below).
    assign trig_busy_c = din && ((state == ST_HIGH) || (state == ST_GAP && cnt != '0));

    // Next-state, counter and queue control.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drop_c    = 1'b0;
`ifdef PULSE_QUEUE_EN
        push_c    = trig_busy_c && !full_c;
        pop_c     = 1'b0;
        drop_c    = trig_busy_c && full_c;
`else
        drop_c    = trig_busy_c;
`endif
        case (state)
            ST_IDLE: begin
                if (din) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = hi_load(len);
                end
            end
            ST_HIGH: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
`ifdef PULSE_QUEUE_EN
                    // Serve the oldest entry; a trigger now is accepted since a slot frees.
                    if (count != '0) begin
                        pop_c     = 1'b1;
                        push_c    = din;
                        state_nxt = ST_HIGH;
                        cnt_nxt   = hi_load(fifo[rd_ptr]);
                    end else if (din) begin
                        // Empty queue: the trigger passes straight through as a queued entry.
                        state_nxt = ST_HIGH;
                        cnt_nxt   = hi_load(len);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`else
                    drop_c    = din;
                    state_nxt = ST_IDLE;
`endif
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= (state_nxt == ST_HIGH);
            drop  <= drop_c;
`ifdef PULSE_QUEUE_EN
            busy  <= (state_nxt != ST_IDLE) || (count_nxt != '0);
`else
            busy  <= (state_nxt != ST_IDLE);
`endif
        end
    end

`ifdef PULSE_QUEUE_EN
    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_c)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo[wr_ptr] <= len;
    end
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: directed scenarios plus random triggers against
// a timeline model (pulse start/end edge numbers and a list of pending lengths).
module tb_pulse_stretcher;

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned GAP    = 1;
    localparam int unsigned QDEPTH = 4;
`ifdef PULSE_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             din = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             dout, busy, drop;

    always #5 clk = ~clk;

    pulse_stretcher #(.LEN_W(LEN_W), .GAP(GAP), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .resetn(resetn),
        .din   (din),
        .len   (len),
        .dout  (dout),
        .busy  (busy),
        .drop  (drop)
    );

    int compared = 0;
    int mismatched = 0;

    // Timeline model: edge index n; active pulse starts at m_s, lasts m_l, next slot at m_x.
    int   n = 0;
    bit   m_active = 1'b0;
    int   m_s, m_l, m_x;
    int   m_q[$];
    logic exp_dout, exp_busy, exp_drop;

    int   pulses, drops;
    logic prev_dout;

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_start(input int t, input int eff);
        m_active = 1'b1;
        m_s = t;
        m_l = eff;
        m_x = t + eff + int'(GAP);
    endtask

    task automatic model_edge(input logic d, input int l);
        int eff;
        eff = (l == 0) ? 1 : l;
        exp_drop = 1'b0;
        if (!m_active) begin
            if (d) model_start(n, eff);
        end else if (n == m_x) begin
            if (m_q.size() > 0) begin
                model_start(n, m_q.pop_front());
                if (d) m_q.push_back(eff);
            end else if (d && QUEUE) begin
                model_start(n, eff);
            end else begin
                m_active = 1'b0;
                if (d) exp_drop = 1'b1;
            end
        end else if (d) begin
            if (QUEUE && m_q.size() < int'(QDEPTH)) m_q.push_back(eff);
            else exp_drop = 1'b1;
        end
        exp_dout = m_active && (n < m_s + m_l);
        exp_busy = m_active || (m_q.size() > 0);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input logic d, input int l);
        din = d;
        len = LEN_W'(l);
        @(posedge clk);
        model_edge(d, l);
        #1;
        chk("dout", dout, exp_dout);
        chk("busy", busy, exp_busy);
        chk("drop", drop, exp_drop);
        if (dout && !prev_dout) pulses++;
        if (drop) drops++;
        prev_dout = dout;
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"}, dout, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_drop"}, drop, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        m_active = 1'b0;
        m_q.delete();
        prev_dout = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pulses = 0;
        drops = 0;
        prev_dout = 1'b0;

        // Outputs held low in reset, including across a clock edge.
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("reset_edge");
        release_reset();

        // Basic pulse, len=3.
        step(1'b1, 3);
        idle(6);

        // Zero length gives a single-cycle pulse.
        pulses = 0;
        step(1'b1, 0);
        idle(4);
        chk_int("zero_len_pulses", pulses, 1);

        // Back-to-back triggers len=2 then len=5.
        pulses = 0;
        drops = 0;
        step(1'b1, 2);
        step(1'b1, 5);
        idle(10);
        chk_int("pair_pulses", pulses, QUEUE ? 2 : 1);
        chk_int("pair_drops", drops, QUEUE ? 0 : 1);

        // Overflow: long pulse, then six triggers while busy.
        pulses = 0;
        drops = 0;
        step(1'b1, 15);
        for (int i = 0; i < 6; i++) step(1'b1, 1 + (i % 3));
        idle(60);
        chk_int("overflow_drops", drops, QUEUE ? 2 : 6);
        chk_int("overflow_pulses", pulses, QUEUE ? 5 : 1);

        // Trigger exactly on the final gap cycle.
        step(1'b1, 2);
        idle(2);
        step(1'b1, 4);
        idle(8);

        // Reset asserted between edges in the middle of a HIGH phase.
        step(1'b1, 9);
        idle(3);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("async_reset_edge");
        release_reset();
        pulses = 0;
        idle(3);
        step(1'b1, 3);
        idle(6);
        chk_int("post_reset_pulses", pulses, 1);

        // Random triggers and lengths.
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
        idle(120);
        chk("final_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter LEN_W, default 4, giving the bit width of the pulse-length input.
REQ-002 SHALL have parameter GAP, default 1, legal range 1..15, giving the minimum number of low cycles between output pulses.
REQ-003 SHALL have parameter QDEPTH, default 4, a power of two, giving the trigger queue depth; it is used only when PULSE_QUEUE_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port din, input, 1 bit: trigger; every cycle sampled high is one trigger.
REQ-007 SHALL have port len, input, LEN_W bits: requested pulse length in cycles, sampled together with the trigger.
REQ-008 SHALL have port dout, output, 1 bit: the stretched output pulse; registered.
REQ-009 SHALL have port busy, output, 1 bit: high while the state is HIGH or GAP, or while the queue is non-empty; registered.
REQ-010 SHALL have port drop, output, 1 bit: a one-cycle pulse in the cycle after a trigger is discarded; registered.

Function
REQ-011 SHALL implement an FSM with states IDLE, HIGH and GAP; dout SHALL be 1 only in HIGH.
REQ-012 SHALL compute the effective length L as len, except that len=0 gives L=1; the maximum L is 2^LEN_W-1.
REQ-013 SHALL, when din=1 is sampled at edge k in IDLE, enter HIGH at edge k so that dout=1 for exactly L cycles starting after edge k (latency 1 cycle).
REQ-014 SHALL, after L cycles in HIGH, enter GAP; dout=0 for exactly GAP cycles.
REQ-015 SHALL, at the end of GAP, go to HIGH with the next queued length if the queue is non-empty; otherwise it SHALL go to IDLE.
REQ-016 SHALL use a down-counter of width max(LEN_W,4) for both the HIGH and GAP durations; it SHALL not wrap and SHALL reload on each state entry.
REQ-017 SHALL handle a trigger in HIGH or GAP as defined in Configuration.
REQ-018 SHALL, when din=1 on the final GAP cycle and the queue is empty, treat it as a busy trigger (queued or dropped), never as an IDLE start.
REQ-019 SHALL assert drop for exactly one cycle per discarded trigger.
REQ-020 SHALL ensure busy=0 implies state IDLE and an empty queue.

Reset
REQ-021 SHALL, while resetn=0, asynchronously force state=IDLE, dout=0, busy=0, drop=0, the counter to 0 and the queue to empty, independent of clk.
REQ-022 SHALL, on reset during HIGH, deassert dout immediately; no pending pulse SHALL resume after reset.
REQ-023 SHALL sample din normally from the first rising clk edge after resetn deasserts.

Configuration
REQ-024 SHALL use the macro PULSE_QUEUE_EN to compile the trigger queue in or out.
REQ-025 SHALL, with PULSE_QUEUE_EN defined, push a busy trigger's len into a QDEPTH-entry FIFO; entries are served in order, each using its own captured len.
REQ-026 SHALL, with PULSE_QUEUE_EN defined and the FIFO full, drop a trigger and assert drop, unless a pop happens in the same cycle; a push and pop in the same cycle SHALL be accepted and leave the occupancy unchanged.
REQ-027 SHALL, with PULSE_QUEUE_EN undefined, contain no FIFO; every trigger in HIGH or GAP is dropped with drop=1, and GAP always exits to IDLE.

Verification
REQ-028 SHALL cover a basic pulse: GAP=1, din=1 for 1 cycle with len=3 -> dout=1 for exactly 3 cycles starting the next cycle, then busy=0 after 1 gap cycle.
REQ-029 SHALL cover a zero length: len=0 trigger -> dout=1 for exactly 1 cycle.
REQ-030 SHALL cover a queued trigger: with PULSE_QUEUE_EN, len=2 then, one cycle later, len=5 -> dout pattern 1,1,0,1,1,1,1,1; drop never asserts.
REQ-031 SHALL cover overflow: with PULSE_QUEUE_EN, QDEPTH=4, len=15, then 6 triggers while busy -> exactly 2 drop pulses and 5 total output pulses.
REQ-032 SHALL cover the no-queue build: without PULSE_QUEUE_EN, a second trigger during HIGH -> drop=1 for one cycle and a single output pulse.
REQ-033 SHALL cover reset mid-operation: resetn=0 asserted mid-HIGH, between clock edges -> dout=0 and busy=0 immediately; the first trigger after release produces a normal pulse.
